dmem_bytelane: RTL
==================

# dmem_bytelane

Parametrised single-port data memory for the pipelined core, successor to the word-only data memory. Adds:
- Byte, halfword, word and (for 64-bit) doubleword loads and stores, with sign/zero extension.
- A registered one-cycle read suited to block-RAM inference.
- A zero-clear sequence after reset.
- A request/acknowledge external read port that shares the array with the MEM stage.

## Interface
Parameters:
- ADDR_W, 9, word-address bits; depth = 2**ADDR_W words
- DATA_W, 32, word width; 32 or 64 only
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip

Ports (OFS = log2(DATA_W/8)):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- mem_read  in  1  load request from control unit
- mem_write  in  1  store request from control unit
- funct3  in  3  access size/sign, RISC-V encoding
- addr  in  ADDR_W+OFS  byte address (ALU result LSBs)
- wd  in  DATA_W  store data, right-aligned
- rd  out  DATA_W  load data, extended
- rd_valid  out  1  rd holds the result of last cycle's load
- misalign  out  1  last cycle's access was misaligned
- busy  out  1  clear sequence running; all requests ignored
- ext_req  in  1  external read request, held until ext_ack
- ext_addr  in  ADDR_W  external word address
- ext_ack  out  1  one-cycle pulse; ext_data valid this cycle
- ext_data  out  DATA_W  external read word

## Operation
- **FSM states**: CLEAR, IDLE.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - CLEAR writes zero to word index cnt, then increments cnt (0 → 2**ADDR_W-1).
  - After the last index, CLEAR → IDLE. busy = (state == CLEAR).
  - Reset asserted mid-clear restarts the sequence at index 0.
- **funct3 encoding**:
  - 000 byte signed, 100 byte unsigned
  - 001 half signed, 101 half unsigned
  - 010 word (sign-extended when DATA_W=64), 110 word unsigned (64 only)
  - 011 doubleword (64 only)
  - Any other code is a full-width access.
- **Stores**: write only the byte lanes selected by size and addr[OFS-1:0]. wd's low bytes are shifted into those lanes; other lanes are untouched.
- **Loads**: extract the lane selected by addr[OFS-1:0], then zero- or sign-extend to DATA_W.
- **mem_read and mem_write together**: read-first. The write is performed, and rd returns the pre-write data.
- **Arbitration**: the core has priority. An ext_req is granted in a cycle with state == IDLE and mem_read == mem_write == 0. The external port may starve under back-to-back core traffic; this is accepted.

## Timing
- Load presented at cycle N → rd and rd_valid=1 at N+1. rd_valid=0 in any cycle not following a load.
- rd holds its last value when rd_valid=0.
- Store commits at the rising edge ending cycle N. A load at N+1 to the same address sees the new data.
- External read granted at cycle G → ext_ack=1 and ext_data at G+1. ext_req may drop at G+1; a new request needs ext_req high again after ack.
- Requests during busy: no write, no rd_valid, no ext_ack.
- Reset values: rd 0, rd_valid 0, misalign 0, ext_ack 0, ext_data 0, cnt 0, busy = CLEAR_ON_RESET.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A misaligned access (half at odd address, word not 4-aligned, doubleword not 8-aligned) pulses misalign at N+1.
  - A misaligned store is suppressed.
  - A misaligned load gives rd_valid=1, rd=0.
- Undefined:
  - addr low bits below the access size are forced to zero (aligned access performed).
  - misalign is tied 0.

## Structure
- Package dmem_pkg:
  - funct3 size enum
  - FSM state enum
  - function returning OFS from DATA_W
- Sub-module dmem_lane_align (combinational): funct3 + addr offset + wd/raw word → byte-enable mask, shifted write data, extended load data.
- The top holds the array, FSM, counter, arbiter and output registers.

## Test plan
- **Reset clear**: rst_n low 3 cycles, CLEAR_ON_RESET=1, ADDR_W=9 → busy high exactly 512 cycles. Every word then reads 0 via ext port.
- **Sub-word store**: SW 0x11223344 @0x10, then SB 0xAB @0x11 → LW @0x10 = 0x1122AB44. LB @0x11 = 0xFFFFFFAB; LBU @0x11 = 0x000000AB.
- **Halfword load**: SH 0x8001 @0x22 → LH @0x22 = 0xFFFF8001. LHU @0x22 = 0x00008001.
- **Arbitration**: ext_req @word 4 during 3 back-to-back loads → ext_ack exactly 2 cycles after the last load's cycle, ext_data = mem[4].
- **Misalignment**:
  - With DMEM_MISALIGN_TRAP_EN: SW @0x03 → misalign=1 next cycle, memory unchanged.
  - Without it: the same access writes word 0.
- **Reset mid-clear**: rst_n pulsed at cnt=100 → clear restarts at 0; busy lasts a full 512 cycles after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
package dmem_pkg;

    // RISC-V load/store funct3 encodings; codes not listed are full-width accesses
    typedef enum logic [2:0] {
        F3_B    = 3'b000,
        F3_H    = 3'b001,
        F3_W    = 3'b010,
        F3_D    = 3'b011,
        F3_BU   = 3'b100,
        F3_HU   = 3'b101,
        F3_WU   = 3'b110,
        F3_FULL = 3'b111
    } funct3_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Byte-offset bits within a word: log2(DATA_W/8)
    function automatic int unsigned ofs_of(input int unsigned data_w);
        return (data_w == 64) ? 3 : 2;
    endfunction

    // log2 of the access size in bytes; anything unrecognised is full width
    function automatic logic [1:0] size_lg(input logic [2:0] f3, input int unsigned ofs);
        case (funct3_e'(f3))
            F3_B, F3_BU: return 2'd0;
            F3_H, F3_HU: return 2'd1;
            F3_W, F3_WU: return 2'd2;
            default:     return 2'(ofs);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_bytelane: byte enables and shifted store data
// for the current access, and extraction/extension of a registered read word.
// DMEM_MISALIGN_TRAP_EN: report misaligned accesses instead of silently aligning.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFS    = 2
)(
    input  logic [2:0]          st_funct3,
    input  logic [OFS-1:0]      st_off,
    input  logic [DATA_W-1:0]   wd,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wdata,
    output logic                misalign,
    input  logic [2:0]          ld_funct3,
    input  logic [OFS-1:0]      ld_off,
    input  logic [DATA_W-1:0]   raw,
    output logic [DATA_W-1:0]   ldata
);

    localparam int unsigned NB = DATA_W / 8;

    logic [1:0]        st_lg;
    logic [OFS-1:0]    st_low;
    logic [OFS-1:0]    st_eff;
    logic [NB-1:0]     st_size_be;

    logic [1:0]        ld_lg;
    logic [OFS-1:0]    ld_low;
    logic [OFS-1:0]    ld_eff;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              sbit;

    // Store side: align offset down to the access size, then shift lanes and data
    always_comb begin
        st_lg      = size_lg(st_funct3, OFS);
        st_low     = '0;
        st_size_be = '0;
        for (int unsigned i = 0; i < OFS; i++)
            st_low[i] = (i < 32'(st_lg));
        for (int unsigned i = 0; i < NB; i++)
            st_size_be[i] = (i < (32'd1 << st_lg));
        st_eff = st_off & ~st_low;
        be     = st_size_be << st_eff;
        wdata  = wd << {st_eff, 3'b000};
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = |(st_off & st_low);
`else
    assign misalign = 1'b0;
`endif

    // Load side: shift the selected lane down, mask to size, sign/zero extend
    always_comb begin
        ld_lg  = size_lg(ld_funct3, OFS);
        ld_low = '0;
        keep   = '0;
        for (int unsigned i = 0; i < OFS; i++)
            ld_low[i] = (i < 32'(ld_lg));
        ld_eff  = ld_off & ~ld_low;
        shifted = raw >> {ld_eff, 3'b000};
        for (int unsigned i = 0; i < NB; i++)
            keep[i*8 +: 8] = {8{i < (32'd1 << ld_lg)}};
        case (ld_lg)
            2'd0:    sbit = shifted[7];
            2'd1:    sbit = shifted[15];
            2'd2:    sbit = shifted[31];
            default: sbit = shifted[DATA_W-1];
        endcase
        sbit  = sbit & ~ld_funct3[2];
        ldata = (shifted & keep) | (sbit ? ~keep : '0);
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Single-port data memory with byte/half/word/double accesses, registered
// read, post-reset zero clear and a low-priority external read port.
// DMEM_MISALIGN_TRAP_EN (in dmem_lane_align): misaligned accesses flag
// misalign, stores are dropped and loads return zero.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned DATA_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [2:0]                       funct3,
    input  logic [ADDR_W+ofs_of(DATA_W)-1:0] addr,
    input  logic [DATA_W-1:0]                wd,
    output logic [DATA_W-1:0]                rd,
    output logic                             rd_valid,
    output logic                             misalign,
    output logic                             busy,
    input  logic                             ext_req,
    input  logic [ADDR_W-1:0]                ext_addr,
    output logic                             ext_ack,
    output logic [DATA_W-1:0]                ext_data
);

    localparam int unsigned OFS   = ofs_of(DATA_W);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clearing;
    logic              idle;

    logic              core_rd, core_wr, ext_grant;
    logic [ADDR_W-1:0] core_idx, widx, ridx;
    logic              we;
    logic [NB-1:0]     st_be, wbe;
    logic [DATA_W-1:0] st_wdata, wdat, raw_q, ldata;
    logic              acc_misalign;

    logic              ld_valid_q, ld_bad_q, misalign_q, ext_ack_q;
    logic [2:0]        ld_f3_q;
    logic [OFS-1:0]    ld_off_q;
    logic [DATA_W-1:0] rd_hold_q, ext_hold_q;

    dmem_lane_align #(
        .DATA_W (DATA_W),
        .OFS    (OFS)
    ) u_align (
        .st_funct3 (funct3),
        .st_off    (addr[OFS-1:0]),
        .wd        (wd),
        .be        (st_be),
        .wdata     (st_wdata),
        .misalign  (acc_misalign),
        .ld_funct3 (ld_f3_q),
        .ld_off    (ld_off_q),
        .raw       (raw_q),
        .ldata     (ldata)
    );

    assign clearing  = (state_q == ST_CLEAR);
    assign idle      = (state_q == ST_IDLE);
    assign busy      = clearing;
    assign core_idx  = addr[ADDR_W+OFS-1:OFS];
    assign core_rd   = idle & mem_read;
    assign core_wr   = idle & mem_write & ~acc_misalign;
    // ack blocks a regrant so a request still high on its ack cycle is not served twice
    assign ext_grant = idle & ~mem_read & ~mem_write & ext_req & ~ext_ack_q;

    // The clear sequence borrows the single write port
    assign we   = clearing | core_wr;
    assign widx = clearing ? cnt_q : core_idx;
    assign wbe  = clearing ? '1 : st_be;
    assign wdat = clearing ? '0 : st_wdata;
    assign ridx = core_rd ? core_idx : ext_addr;

    // Clear/idle state and clear index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Walk every word index once, then go idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1)
                state_d = ST_IDLE;
        end
    end

    // Byte-enabled write with read-first registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NB; i++)
                if (wbe[i])
                    mem[widx][i*8 +: 8] <= wdat[i*8 +: 8];
        end
        raw_q <= mem[ridx];
    end

    // Per-access control captured alongside the RAM read, plus output hold values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_valid_q <= 1'b0;
            ld_bad_q   <= 1'b0;
            ld_f3_q    <= '0;
            ld_off_q   <= '0;
            misalign_q <= 1'b0;
            ext_ack_q  <= 1'b0;
            rd_hold_q  <= '0;
            ext_hold_q <= '0;
        end else begin
            ld_valid_q <= core_rd;
            ld_bad_q   <= acc_misalign;
            if (core_rd) begin
                ld_f3_q  <= funct3;
                ld_off_q <= addr[OFS-1:0];
            end
            misalign_q <= idle & (mem_read | mem_write) & acc_misalign;
            ext_ack_q  <= ext_grant;
            rd_hold_q  <= rd;
            ext_hold_q <= ext_data;
        end
    end

    // Outputs follow the RAM word in the cycle after the access, else hold
    always_comb begin
        rd       = ld_valid_q ? (ld_bad_q ? '0 : ldata) : rd_hold_q;
        ext_data = ext_ack_q ? raw_q : ext_hold_q;
    end

    assign rd_valid = ld_valid_q;
    assign misalign = misalign_q;
    assign ext_ack  = ext_ack_q;

endmodule
